// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared widths, defaults and arbiter state encoding
package cpu_defs;
  localparam int DW               = 32;
  localparam int AW_DEF           = 10;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPU_RD = 2'd1,
    ST_DMA_RD = 2'd2
  } arb_state_e;
endpackage

// File: rtl/arb_starve_counter.sv
// rtl/arb_starve_counter.sv - saturating count of CPU grants taken while the DMA waits
module arb_starve_counter
  import cpu_defs::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cpu_gnt_i,
  input  logic dma_gnt_i,
  input  logic dma_req_i,
  output logic starved_o
);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (dma_gnt_i || !dma_req_i) begin
      cnt_d = '0;
    end else if (cpu_gnt_i && (cnt_q < LIMIT_C)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved_o = (cnt_q >= LIMIT_C);
endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - single-port RAM shared between CPU and DMA with starvation guard
module ram_port_arbiter
  import cpu_defs::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int AW           = AW_DEF
) (
  input  logic          MAX10_CLK1_50,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_rden,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q
);
  arb_state_e state_q, state_d;
  logic       starved;
  logic       cpu_win;
  logic       dma_win;

  arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk_i     (MAX10_CLK1_50),
    .rst_i     (reset),
    .cpu_gnt_i (cpu_win),
    .dma_gnt_i (dma_win),
    .dma_req_i (dma_req),
    .starved_o (starved)
  );

  // Everything is gated by reset so outputs drop to zero the instant reset rises.
  always_comb begin
    state_d     = state_q;
    cpu_win     = 1'b0;
    dma_win     = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    ram_rden    = 1'b0;
    ram_wren    = 1'b0;
    cpu_rdata   = '0;
    cpu_stall   = 1'b0;
    dma_gnt     = 1'b0;
    dma_rvalid  = 1'b0;
    dma_rdata   = '0;
    if (!reset) begin
      unique case (state_q)
        ST_IDLE: begin
          cpu_win = cpu_req && !starved;
          dma_win = dma_req && !cpu_win;
          if (cpu_win) begin
            ram_address = cpu_addr;
            ram_wren    = cpu_we;
            ram_rden    = !cpu_we;
            if (cpu_we) begin
              ram_data = cpu_wdata;
            end else begin
              state_d = ST_CPU_RD;
            end
          end else if (dma_win) begin
            dma_gnt     = 1'b1;
            ram_address = dma_addr;
            ram_wren    = dma_we;
            ram_rden    = !dma_we;
            if (dma_we) begin
              ram_data = dma_wdata;
            end else begin
              state_d = ST_DMA_RD;
            end
          end
        end
        ST_CPU_RD: begin
          cpu_rdata = ram_q;
          state_d   = ST_IDLE;
        end
        ST_DMA_RD: begin
          dma_rdata  = ram_q;
          dma_rvalid = 1'b1;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      cpu_stall = cpu_req && !((cpu_win && cpu_we) || (state_q == ST_CPU_RD));
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive CPU grants allowed while DMA waits.
REQ-002 SHALL have parameter AW, default 10: RAM word-address width (1024 words).
REQ-003 SHALL have port MAX10_CLK1_50 input 1: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset input 1: asynchronous, active-high reset.
REQ-005 SHALL have port cpu_req input 1: CPU load/store request, level, held until cpu_stall is low.
REQ-006 SHALL have port cpu_we input 1: CPU request is a write when high.
REQ-007 SHALL have port cpu_addr input AW: CPU word address.
REQ-008 SHALL have port cpu_wdata input 32: CPU store data.
REQ-009 SHALL have port cpu_rdata output 32: CPU load data.
REQ-010 SHALL have port cpu_stall output 1: holds the PC and pipeline while the CPU access is incomplete.
REQ-011 SHALL have port dma_req input 1: loader/DMA request, level, held until dma_gnt.
REQ-012 SHALL have port dma_we input 1: DMA request is a write when high.
REQ-013 SHALL have port dma_addr input AW: DMA word address.
REQ-014 SHALL have port dma_wdata input 32: DMA write data.
REQ-015 SHALL have port dma_gnt output 1: one-cycle pulse when the DMA command is on the RAM port.
REQ-016 SHALL have port dma_rvalid output 1: one-cycle pulse when dma_rdata is valid.
REQ-017 SHALL have port dma_rdata output 32: DMA read data.
REQ-018 SHALL have ports ram_address output AW, ram_data output 32, ram_rden output 1, ram_wren output 1: RAM command.
REQ-019 SHALL have port ram_q input 32: RAM read data, valid one cycle after ram_rden.

Function
REQ-020 SHALL implement the FSM states IDLE, CPU_RD and DMA_RD.
REQ-021 In IDLE, a command SHALL be issued to the winner in the same cycle, combinationally from the requests.
REQ-022 Winner SHALL be the CPU if cpu_req is high and starve_cnt < STARVE_LIMIT; otherwise the DMA if dma_req is high; otherwise none.
REQ-023 A granted write SHALL drive ram_wren=1, ram_rden=0 and the requester's address/data, complete in that cycle, and keep the state at IDLE.
REQ-024 A granted read SHALL drive ram_rden=1 and move to CPU_RD or DMA_RD.
REQ-025 In CPU_RD/DMA_RD, ram_rden and ram_wren SHALL be 0 with no new grant, and the next state SHALL be IDLE.
REQ-026 In CPU_RD, cpu_rdata SHALL equal ram_q and cpu_stall SHALL be 0.
REQ-027 In DMA_RD, dma_rdata SHALL equal ram_q and dma_rvalid SHALL be 1.
REQ-028 cpu_stall SHALL equal cpu_req AND NOT(CPU write granted this cycle OR state==CPU_RD).
REQ-029 With no command issued, ram_address and ram_data SHALL be 0.
REQ-030 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each CPU grant while dma_req is high.
REQ-031 starve_cnt SHALL clear on a DMA grant or when dma_req is low.
REQ-032 If both requests are simultaneous with starve_cnt==STARVE_LIMIT, the DMA SHALL win and the CPU SHALL stall that cycle.
REQ-033 Request or address changes during a *_RD state SHALL be ignored until IDLE.

Reset
REQ-034 While reset is high, the state SHALL be IDLE, starve_cnt 0, and all outputs 0 (cpu_stall 0).
REQ-035 A reset during CPU_RD/DMA_RD SHALL abort the access with no rvalid pulse; after release, arbitration SHALL restart from IDLE.

Structure
REQ-036 The state encoding, AW, data width 32 and STARVE_LIMIT default SHALL live in the shared cpu_defs package/include.
REQ-037 The saturating starvation counter SHALL be one sub-module, arb_starve_counter.

Verification
REQ-038 CPU read addr 0x005, RAM[5]=0xDEADBEEF -> rden at cycle 0, stall=1; cycle 1 cpu_rdata=0xDEADBEEF, stall=0.
REQ-039 CPU write addr 0x3FF, data 0x12345678, idle DMA -> wren for 1 cycle, stall never 1, RAM[0x3FF] readback matches.
REQ-040 cpu_req and dma_req both held, all reads, STARVE_LIMIT=4 -> 4 CPU grants, then 1 DMA grant with dma_rvalid, then CPU again.
REQ-041 DMA write then DMA read to 0x010 with CPU idle -> dma_gnt pulses on both, rvalid returns the written value.
REQ-042 reset asserted in DMA_RD -> no dma_rvalid, outputs 0 immediately, first post-reset CPU read served normally.
